// File: rtl/uhf_tx_framer.sv
// uhf_tx_framer
//   Builds one UHF burst as a serial bit stream for the downstream scrambler:
//   PTT key-up lead (zeros, scrambler held), 0x55 preamble bytes, 32-bit sync
//   word, i_len payload bytes fetched through a one-byte holding register,
//   then 0x00 tail bytes. Every bit, bit counter and byte counter advances only
//   on i_bit_stb; o_tx_bit changes on the edge that samples the strobe and
//   holds for the whole bit period.
//
//   Parameters (PTT_LEAD_BITS, PREAMBLE_BYTES and TAIL_BYTES must each be >= 1)
//     PTT_LEAD_BITS   bit periods of key-up before the first preamble bit
//     PREAMBLE_BYTES  number of 0x55 preamble bytes
//     SYNC_WORD       32-bit sync pattern, sent MSB first
//     TAIL_BYTES      number of 0x00 tail bytes
//
//   Ports
//     i_clk          system clock, rising edge
//     i_reset        synchronous active-high reset
//     i_bit_stb      one-cycle strobe per TX bit period
//     i_start        frame request, sampled in IDLE only
//     i_len          payload byte count (0 = invalid, request ignored)
//     i_data         payload byte
//     i_data_valid   i_data is valid
//     o_data_ready   framer accepts i_data this cycle
//     o_tx_bit       unscrambled bit to the scrambler
//     o_scr_en       scrambler enable (0 keeps scrambler cleared)
//     o_ptt          transmitter key
//     o_busy         frame in progress
//     o_done         one-cycle pulse at end of frame
//     o_underrun     payload source ran dry; sticky until next accepted start
module uhf_tx_framer #(
    parameter int unsigned PTT_LEAD_BITS  = 16,
    parameter int unsigned PREAMBLE_BYTES = 8,
    parameter logic [31:0] SYNC_WORD      = 32'h1ACFFC1D,
    parameter int unsigned TAIL_BYTES     = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_bit_stb,
    input  logic       i_start,
    input  logic [7:0] i_len,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_data_ready,
    output logic       o_tx_bit,
    output logic       o_scr_en,
    output logic       o_ptt,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYUP,
        S_PREAMBLE,
        S_SYNC,
        S_PAYLOAD,
        S_TAIL,
        S_DONE
    } state_t;

    localparam logic [15:0] LEAD_LAST = 16'(PTT_LEAD_BITS - 1);
    localparam logic [8:0]  PRE_LAST  = 9'(PREAMBLE_BYTES - 1);
    localparam logic [8:0]  TAIL_N    = 9'(TAIL_BYTES);

    state_t      state;
    logic [7:0]  len_q;
    logic [15:0] lead_cnt;
    logic [2:0]  bit_cnt;     // bit position within the current byte
    logic [8:0]  byte_cnt;    // bytes completed in the current section
    logic [8:0]  fetch_cnt;   // payload bytes accepted from the source
    logic [7:0]  shreg;
    logic [7:0]  hold;
    logic        hold_full;

    logic        data_ready_c;
    logic        accept;
    logic        boundary;
    logic [7:0]  sync_byte;
    logic [7:0]  new_byte;
    logic [7:0]  tx_src;

    assign data_ready_c = !i_reset && !hold_full &&
                          ((state == S_SYNC) || (state == S_PAYLOAD)) &&
                          (fetch_cnt < {1'b0, len_q});
    assign accept       = i_data_valid && data_ready_c;
    assign o_data_ready = data_ready_c;
    assign boundary     = (bit_cnt == 3'd0);

    always_comb begin
        sync_byte = SYNC_WORD[31:24];
        unique case (byte_cnt[1:0])
            2'd0: sync_byte = SYNC_WORD[31:24];
            2'd1: sync_byte = SYNC_WORD[23:16];
            2'd2: sync_byte = SYNC_WORD[15:8];
            2'd3: sync_byte = SYNC_WORD[7:0];
        endcase
    end

    // Byte that starts at a boundary strobe. In PAYLOAD, a byte accepted in the
    // very cycle of the boundary (holding register still empty) is passed
    // straight through so it is not lost.
    always_comb begin
        new_byte = 8'h00;
        unique case (state)
            S_PREAMBLE: new_byte = 8'h55;
            S_SYNC:     new_byte = sync_byte;
            S_PAYLOAD:  new_byte = hold_full ? hold : i_data;
            default:    new_byte = 8'h00;
        endcase
        tx_src = boundary ? new_byte : shreg;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            lead_cnt   <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            fetch_cnt  <= '0;
            shreg      <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            o_tx_bit   <= 1'b0;
            o_scr_en   <= 1'b0;
            o_ptt      <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_done <= 1'b0;

            if (accept) begin
                hold      <= i_data;
                hold_full <= 1'b1;
                fetch_cnt <= fetch_cnt + 9'd1;
            end

            unique case (state)
                S_IDLE: begin
                    if (i_start && (i_len != '0)) begin
                        state      <= S_KEYUP;
                        len_q      <= i_len;
                        o_underrun <= 1'b0;
                        o_ptt      <= 1'b1;
                        o_busy     <= 1'b1;
                        lead_cnt   <= '0;
                        bit_cnt    <= '0;
                        byte_cnt   <= '0;
                        fetch_cnt  <= '0;
                        hold_full  <= 1'b0;
                    end
                end

                S_KEYUP: begin
                    if (i_bit_stb) begin
                        o_tx_bit <= 1'b0;
                        if (lead_cnt == LEAD_LAST) begin
                            state    <= S_PREAMBLE;
                            lead_cnt <= '0;
                        end else begin
                            lead_cnt <= lead_cnt + 16'd1;
                        end
                    end
                end

                S_PREAMBLE: begin
                    if (i_bit_stb) begin
                        o_scr_en <= 1'b1;
                        o_tx_bit <= tx_src[7];
                        shreg    <= {tx_src[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt == PRE_LAST) begin
                                state    <= S_SYNC;
                                byte_cnt <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 9'd1;
                            end
                        end
                    end
                end

                S_SYNC: begin
                    if (i_bit_stb) begin
                        o_tx_bit <= tx_src[7];
                        shreg    <= {tx_src[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt == 9'd3) begin
                                state    <= S_PAYLOAD;
                                byte_cnt <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 9'd1;
                            end
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (i_bit_stb) begin
                        if (boundary && !hold_full && !accept) begin
                            // Source ran dry: the first tail bit goes out on this
                            // same strobe so the tail follows without a gap.
                            o_underrun <= 1'b1;
                            state      <= S_TAIL;
                            o_tx_bit   <= 1'b0;
                            shreg      <= '0;
                            bit_cnt    <= 3'd1;
                            byte_cnt   <= '0;
                        end else begin
                            o_tx_bit <= tx_src[7];
                            shreg    <= {tx_src[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (boundary) begin
                                hold_full <= 1'b0;
                            end
                            if (bit_cnt == 3'd7) begin
                                if ((byte_cnt + 9'd1) == {1'b0, len_q}) begin
                                    state    <= S_TAIL;
                                    byte_cnt <= '0;
                                end else begin
                                    byte_cnt <= byte_cnt + 9'd1;
                                end
                            end
                        end
                    end
                end

                S_TAIL: begin
                    if (i_bit_stb) begin
                        // The strobe after the last tail bit closes the frame.
                        if (boundary && (byte_cnt == TAIL_N)) begin
                            state    <= S_DONE;
                            o_done   <= 1'b1;
                            o_ptt    <= 1'b0;
                            o_busy   <= 1'b0;
                            o_scr_en <= 1'b0;
                            o_tx_bit <= 1'b0;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                        end else begin
                            o_tx_bit <= tx_src[7];
                            shreg    <= {tx_src[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 9'd1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uhf_tx_framer.sv
// Randomized self-checking bench for uhf_tx_framer. The reference model builds
// the expected bit stream of each frame from the frame layout and the strobe
// numbers at which payload bytes were handed over.
module tb_uhf_tx_framer;

    localparam int LEAD = 16;
    localparam int PRE  = 2;
    localparam int TAIL = 1;
    localparam logic [31:0] SYNC = 32'h1ACFFC1D;
    // strobe number (counted from 1 after start) carrying the first payload bit
    localparam int PAY0 = LEAD + 8 * PRE + 32 + 1;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_bit_stb;
    logic       i_start;
    logic [7:0] i_len;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       o_data_ready;
    logic       o_tx_bit;
    logic       o_scr_en;
    logic       o_ptt;
    logic       o_busy;
    logic       o_done;
    logic       o_underrun;

    always #5 i_clk = ~i_clk;

    uhf_tx_framer #(
        .PTT_LEAD_BITS (LEAD),
        .PREAMBLE_BYTES(PRE),
        .SYNC_WORD     (SYNC),
        .TAIL_BYTES    (TAIL)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_bit_stb   (i_bit_stb),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_data      (i_data),
        .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready),
        .o_tx_bit    (o_tx_bit),
        .o_scr_en    (o_scr_en),
        .o_ptt       (o_ptt),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_underrun  (o_underrun)
    );

    int total = 0;
    int bad   = 0;

    int   stb_per = 1;
    int   stb_phase = 0;
    bit   in_frame = 1'b0;
    int   sc, done_cnt, done_sc, cur_len, max_gap, sup_gap;
    bit   mid_start, mid_reset, rst_fired;
    logic [7:0] sup_q[$];
    logic [7:0] acc_data[$];
    int         acc_stamp[$];
    logic       bits_q[$];
    logic       scr_q[$];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe 1 time unit after the rise.
    task automatic cyc();
        bit stb;
        bit acc;
        stb       = (stb_phase == 0);
        stb_phase = (stb_phase + 1) % stb_per;
        i_bit_stb = stb;
        i_start   = 1'b0;
        if (in_frame && mid_start && sc >= PAY0 + 3 && sc <= PAY0 + 5) begin
            i_start = 1'b1;
            i_len   = 8'($urandom_range(1, 255));
        end
        if (in_frame && mid_reset && !rst_fired && sc >= LEAD + 8 * PRE + 10) begin
            i_reset   = 1'b1;
            rst_fired = 1'b1;
        end
        if (in_frame && sup_q.size() > 0 && !rst_fired) begin
            if (sup_gap > 0) begin
                i_data_valid = 1'b0;
                sup_gap--;
            end else begin
                i_data_valid = 1'b1;
                i_data       = sup_q[0];
            end
        end else begin
            i_data_valid = 1'b0;
        end
        #1;
        if (in_frame && i_reset) check("rst_ready", int'(o_data_ready), 0);
        acc = i_data_valid && o_data_ready;
        @(posedge i_clk);
        #1;
        if (in_frame) begin
            if (i_reset) begin
                check("rst_outs", int'({o_ptt, o_busy, o_scr_en, o_done, o_tx_bit}), 0);
            end else begin
                if (stb) sc++;
                if (acc) begin
                    acc_stamp.push_back(stb ? 2 * sc : 2 * sc + 1);
                    acc_data.push_back(sup_q.pop_front());
                    sup_gap = $urandom_range(0, max_gap);
                    if (acc_stamp.size() == cur_len)
                        check("ready_drop", int'(o_data_ready), 0);
                end
                if (o_done) begin
                    done_cnt++;
                    done_sc = sc;
                    check("done_outs", int'({o_ptt, o_busy, o_scr_en}), 0);
                end else if (stb && done_cnt == 0) begin
                    bits_q.push_back(o_tx_bit);
                    scr_q.push_back(o_scr_en);
                end
            end
        end
        @(negedge i_clk);
    endtask

    task automatic push_byte(inout logic q[$], input logic [7:0] b);
        for (int i = 7; i >= 0; i--) q.push_back(b[i]);
    endtask

    task automatic run_frame(input int len, input int nsup, input int gap, input int per,
                             input bit ms, input bit mr, input bit fixed);
        logic exp_q[$];
        int   nload;
        int   mism;
        int   smis;
        int   guard;
        int   n;
        sup_q.delete();
        acc_data.delete();
        acc_stamp.delete();
        bits_q.delete();
        scr_q.delete();
        for (int i = 0; i < nsup; i++) sup_q.push_back(8'($urandom));
        if (fixed) begin
            sup_q[0] = 8'hA5;
            sup_q[1] = 8'h3C;
        end
        cur_len   = len;
        max_gap   = gap;
        sup_gap   = (gap == 0) ? 0 : $urandom_range(0, gap);
        stb_per   = per;
        mid_start = ms;
        mid_reset = mr;
        rst_fired = 1'b0;
        sc        = 0;
        done_cnt  = 0;
        done_sc   = 0;

        i_start      = 1'b1;
        i_len        = 8'(len);
        i_bit_stb    = 1'b0;
        i_data_valid = 1'b0;
        @(posedge i_clk);
        #1;
        check("start_keys", int'({o_ptt, o_busy, o_underrun}), 6);
        i_start = 1'b0;
        @(negedge i_clk);
        stb_phase = 0;
        in_frame  = 1'b1;

        guard = 0;
        while (done_cnt == 0 && !rst_fired && guard < 20000) begin
            cyc();
            guard++;
        end

        if (rst_fired) begin
            i_reset  = 1'b0;
            in_frame = 1'b0;
            for (int i = 0; i < 6; i++) begin
                cyc();
                check("rst_quiet", int'({o_ptt, o_busy, o_done, o_scr_en}), 0);
            end
            return;
        end

        for (int i = 0; i < 4; i++) cyc();
        in_frame     = 1'b0;
        i_data_valid = 1'b0;

        // Expected frame: lead zeros, preamble, sync, payload bytes that were in
        // hand by their boundary strobe, tail.
        for (int i = 0; i < LEAD; i++) exp_q.push_back(1'b0);
        for (int p = 0; p < PRE; p++) push_byte(exp_q, 8'h55);
        for (int i = 31; i >= 0; i--) exp_q.push_back(SYNC[i]);
        nload = 0;
        for (int k = 0; k < len; k++) begin
            if (k < acc_stamp.size() && acc_stamp[k] <= 2 * (PAY0 + 8 * k)) begin
                push_byte(exp_q, acc_data[k]);
                nload++;
            end else begin
                break;
            end
        end
        for (int i = 0; i < 8 * TAIL; i++) exp_q.push_back(1'b0);

        check("nbits", bits_q.size(), exp_q.size());
        n = (bits_q.size() < exp_q.size()) ? bits_q.size() : exp_q.size();
        mism = 0;
        smis = 0;
        for (int i = 0; i < n; i++) begin
            if (bits_q[i] !== exp_q[i]) mism++;
            if (scr_q[i] !== (i >= LEAD)) smis++;
        end
        check("bits", mism, 0);
        check("scr_en", smis, 0);
        check("done_cnt", done_cnt, 1);
        check("done_at", done_sc, exp_q.size() + 1);
        check("underrun", int'(o_underrun), (nload < len) ? 1 : 0);
        check("fetched", acc_stamp.size(), nload);
    endtask

    initial begin
        int len;
        int nsup;
        i_reset      = 1'b1;
        i_bit_stb    = 1'b0;
        i_start      = 1'b0;
        i_len        = '0;
        i_data       = '0;
        i_data_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_outs",
              int'({o_tx_bit, o_scr_en, o_ptt, o_busy, o_done, o_underrun, o_data_ready}), 0);
        i_reset = 1'b0;

        // zero-length request must be ignored
        i_start = 1'b1;
        i_len   = 8'd0;
        @(posedge i_clk);
        #1;
        check("len0_ptt", int'({o_ptt, o_busy}), 0);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) cyc();
        check("len0_idle", int'({o_ptt, o_busy, o_scr_en}), 0);

        // 2-byte frame with prompt source, continuous strobes
        run_frame(2, 2, 0, 1, 1'b0, 1'b0, 1'b1);
        // source supplies only 1 of 3 bytes
        run_frame(3, 1, 0, 2, 1'b0, 1'b0, 1'b0);
        // i_start pulsed during payload
        run_frame(4, 4, 2, 3, 1'b1, 1'b0, 1'b0);
        // reset during sync, then a clean frame
        run_frame(4, 4, 1, 2, 1'b0, 1'b1, 1'b0);
        run_frame(3, 3, 1, 2, 1'b0, 1'b0, 1'b0);
        // maximum length with continuous strobe
        run_frame(255, 255, 0, 1, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 12; f++) begin
            len  = $urandom_range(1, 10);
            nsup = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
            run_frame(len, nsup, $urandom_range(0, 30), $urandom_range(1, 4),
                      1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uhf_tx_framer.md
UHF_TX_FRAMER -- requirements
Module: uhf_tx_framer

Interface
REQ-001 SHALL provide parameter PTT_LEAD_BITS, default 16, meaning bit periods of PTT key-up before the first preamble bit.
REQ-002 SHALL provide parameter PREAMBLE_BYTES, default 8, meaning count of 0x55 preamble bytes.
REQ-003 SHALL provide parameter SYNC_WORD, default 32'h1ACFFC1D, meaning the sync pattern, sent MSB first.
REQ-004 SHALL provide parameter TAIL_BYTES, default 2, meaning count of 0x00 tail bytes after the payload.
REQ-005 SHALL provide port i_clk, input, 1, system clock; all logic on the rising edge.
REQ-006 SHALL provide port i_reset, input, 1; reset is synchronous, active-high.
REQ-007 SHALL provide port i_bit_stb, input, 1, one-cycle strobe per TX bit period.
REQ-008 SHALL provide port i_start, input, 1, frame request, sampled in IDLE only.
REQ-009 SHALL provide port i_len, input, 8, payload byte count; 0 is invalid.
REQ-010 SHALL provide port i_data, input, 8, payload byte.
REQ-011 SHALL provide port i_data_valid, input, 1, i_data valid.
REQ-012 SHALL provide port o_data_ready, output, 1, framer accepts i_data this cycle.
REQ-013 SHALL provide port o_tx_bit, output, 1, unscrambled bit to the scrambler TX input.
REQ-014 SHALL provide port o_scr_en, output, 1, scrambler enable; 0 holds scrambler state cleared.
REQ-015 SHALL provide port o_ptt, output, 1, transmitter key.
REQ-016 SHALL provide ports o_busy (1), o_done (1, one-cycle pulse) and o_underrun (1, sticky until next accepted start).

Function
REQ-017 SHALL implement states IDLE, KEYUP, PREAMBLE, SYNC, PAYLOAD, TAIL, DONE.
REQ-018 SHALL move IDLE->KEYUP on i_start=1 with i_len!=0, latching i_len, clearing o_underrun, asserting o_ptt and o_busy the next cycle; i_start with i_len=0 is ignored.
REQ-019 SHALL advance the bit shift and all bit/byte counters only on cycles with i_bit_stb=1; o_tx_bit updates on the clock edge that samples i_bit_stb=1 and holds until the next strobe.
REQ-020 SHALL drive o_tx_bit=0 and o_scr_en=0 in IDLE and KEYUP; KEYUP lasts exactly PTT_LEAD_BITS strobes.
REQ-021 SHALL assert o_scr_en from the strobe that emits the first preamble bit until the strobe after the last tail bit.
REQ-022 SHALL emit all bytes MSB first: PREAMBLE_BYTES x 0x55, then 32 SYNC_WORD bits, then i_len payload bytes, then TAIL_BYTES x 0x00.
REQ-023 SHALL use a single-byte holding register; o_data_ready=1 when it is empty, the state is SYNC or PAYLOAD, and fewer than i_len bytes have been fetched; a byte is accepted when i_data_valid and o_data_ready are both 1.
REQ-024 SHALL load the shift register from the holding register at each payload byte boundary (the strobe after the previous byte's bit 0), emptying it in the same cycle.
REQ-025 SHALL, if the holding register is empty at a payload byte boundary, set o_underrun, stop fetching, and go directly to TAIL.
REQ-026 SHALL give priority to the shift-register load when a byte accept and a byte-boundary load coincide; the accepted byte is not lost.
REQ-027 SHALL move TAIL->DONE after the last tail bit's strobe; DONE deasserts o_ptt, o_busy and o_scr_en, pulses o_done for one cycle, and returns to IDLE.
REQ-028 SHALL ignore i_start while o_busy=1.
REQ-029 SHALL use payload byte counters of 9 bits so that i_len=255 does not wrap.

Reset
REQ-030 SHALL, while i_reset=1, force state IDLE and drive o_tx_bit=0, o_scr_en=0, o_ptt=0, o_busy=0, o_done=0, o_underrun=0, o_data_ready=0, with all counters and the holding register cleared.
REQ-031 SHALL, on reset mid-frame, drop o_ptt on the next clock with no tail and no o_done pulse.

Verification
REQ-032 SHALL cover this scenario: PREAMBLE_BYTES=2, TAIL_BYTES=1, i_len=2, bytes 0xA5 and 0x3C supplied promptly -> 16 zeros in KEYUP, then 0x55 0x55, 0x1ACFFC1D, 0xA5 0x3C, 0x00; 88 strobes after start; o_done pulses once; o_underrun=0.
REQ-033 SHALL cover this scenario: i_len=3, only 1 byte supplied -> after byte 1, o_underrun=1, tail follows immediately, o_done pulses.
REQ-034 SHALL cover this scenario: i_start=1 with i_len=0 -> remains IDLE, o_ptt=0.
REQ-035 SHALL cover this scenario: i_start pulsed during PAYLOAD -> no effect on the frame bit sequence.
REQ-036 SHALL cover this scenario: i_reset=1 during SYNC -> next cycle o_ptt=0, o_busy=0, o_scr_en=0, no o_done; a new start then produces a complete correct frame.
REQ-037 SHALL cover this scenario: i_bit_stb held 1 continuously with i_len=255 -> 255 payload bytes emitted, o_data_ready drops after the 255th accept.
